wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Write-back end of the MIPS pipeline. It consumes the W-stage signals that the MEM/WB pipeline register produces and selects the write-back result. It commits that result into a 32-entry general-purpose register file and serves the two decode-stage read ports with same-cycle write bypass. It also keeps a count of committed register writes for debug and performance monitoring.

Parameters:
DATA_WIDTH, 32, width of register data, ALUOutW, ReadDataW and ResultW
ADDR_WIDTH, 5, register address width; the file holds 2**ADDR_WIDTH entries
CNT_WIDTH, 32, width of the committed-write counter

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous, active-low reset
ALUOutW  input  DATA_WIDTH  ALU result from the W stage
ReadDataW  input  DATA_WIDTH  load data from the W stage
WriteRegW  input  ADDR_WIDTH  destination register
RegWriteW  input  1  register write enable
MemtoRegW  input  1  1 = write ReadDataW, 0 = write ALUOutW
A1  input  ADDR_WIDTH  read address, port 1 (rs)
A2  input  ADDR_WIDTH  read address, port 2 (rt)
RD1  output  DATA_WIDTH  read data, port 1
RD2  output  DATA_WIDTH  read data, port 2
ResultW  output  DATA_WIDTH  selected write-back value (fed to the forwarding paths)
WriteCount  output  CNT_WIDTH  number of committed writes since reset

Behaviour:
- Reset:
  - One clock, CLK; RST is asynchronous and active-low.
  - While RST is low: all registers are 0, WriteCount is 0, RD1 = RD2 = 0.
  - ResultW stays purely combinational and is unaffected by RST.
  - Asserting RST mid-operation clears all state immediately, without waiting for a clock edge. The first write after RST rises happens on the first rising CLK edge that meets the commit condition.
- Result select (combinational, zero latency): ResultW = MemtoRegW ? ReadDataW : ALUOutW.
- Commit condition: commit = RegWriteW && (WriteRegW != 0) && RST.
- Write: on the rising CLK edge with commit true, reg[WriteRegW] <= ResultW. The new value is visible at the read ports through the array from the next cycle on.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded and are not counted.
  - Reads of address 0 return 0 regardless of any bypass.
- Reads are asynchronous and combinational. Per port n, in priority order:
  - An = 0 -> RDn = 0.
  - Otherwise, commit && An == WriteRegW -> RDn = ResultW (write-first bypass in the same cycle).
  - Otherwise -> RDn = reg[An].
- Both ports may hit the bypass at once (A1 == A2 == WriteRegW); both then return ResultW.
- RegWriteW = 0 -> no write and no bypass, even if the address matches.
- WriteCount:
  - Increments by 1 on every rising edge where commit is true.
  - Wraps modulo 2**CNT_WIDTH: all-ones + 1 -> 0, with no sticky flag.
- X-safety: when RegWriteW = 0, the values of WriteRegW, ALUOutW and ReadDataW must not affect any state.

Test Plan:
- Reset then read: RST low, then high. A1 = 5 and A2 = 31 -> RD1 = RD2 = 0x00000000 and WriteCount = 0.
- ALU write: RegWriteW = 1, MemtoRegW = 0, ALUOutW = 0xDEADBEEF, WriteRegW = 8, A1 = 8 -> RD1 = 0xDEADBEEF combinationally in the same cycle (bypass). After the edge with RegWriteW = 0, RD1 still reads 0xDEADBEEF and WriteCount = 1.
- Load select: MemtoRegW = 1, ReadDataW = 0x12345678, ALUOutW = 0xFFFFFFFF, WriteRegW = 9, RegWriteW = 1 -> ResultW = 0x12345678. After the edge, A2 = 9 reads 0x12345678.
- $0 protection: RegWriteW = 1, WriteRegW = 0, ALUOutW = 0xAAAAAAAA, A1 = A2 = 0 -> RD1 = RD2 = 0 before and after the edge. WriteCount is unchanged.
- Dual bypass and disabled write: A1 = A2 = WriteRegW = 3 with RegWriteW = 1 and ResultW = 0x55 -> RD1 = RD2 = 0x55. Repeat with RegWriteW = 0 -> both ports return the old reg[3], and reg[3] is unchanged after the edge.
- Counter wrap and async reset: use CNT_WIDTH = 4 and run 17 committed writes -> WriteCount = 1. Then assert RST between clock edges -> WriteCount, RD1 and RD2 drop to 0 at once, and reg[8] reads 0 after RST is released.

Source files
------------

// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects the W-stage result, commits it to a 32-entry
// register file with $0 hardwired to zero, and counts committed writes.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] ALUOutW,
    input  logic [DATA_WIDTH-1:0] ReadDataW,
    input  logic [ADDR_WIDTH-1:0] WriteRegW,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegW,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic [CNT_WIDTH-1:0]  WriteCount
);

    localparam int                   NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  commit;

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

    // RegWriteW gates everything else, so junk on the other W-stage inputs
    // cannot leak into state or into the bypass while the write is disabled.
    assign commit = RegWriteW && (WriteRegW != '0) && RST;

    // NOTE: the array is cleared by the async reset because reads must
    // return 0 for every register while RST is low; this costs a reset
    // net on every storage bit, so do not copy it where plain RAM suffices.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            regs[WriteRegW] <= ResultW;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            WriteCount <= '0;
        end else if (commit) begin
            WriteCount <= WriteCount + CNT_ONE;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the block leaves the
        // output unassigned, which would infer a latch.
        RD1 = regs[A1];
        if (A1 == '0) begin
            RD1 = '0;
        end else if (commit && (A1 == WriteRegW)) begin
            RD1 = ResultW;
        end
    end

    always_comb begin
        RD2 = regs[A2];
        if (A2 == '0) begin
            RD2 = '0;
        end else if (commit && (A2 == WriteRegW)) begin
            RD2 = ResultW;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; the counter is narrowed to
// 4 bits so the wrap case is reachable in a handful of writes.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] ALUOutW;
    logic [DW-1:0] ReadDataW;
    logic [AW-1:0] WriteRegW;
    logic          RegWriteW;
    logic          MemtoRegW;
    logic [AW-1:0] A1;
    logic [AW-1:0] A2;
    logic [DW-1:0] RD1;
    logic [DW-1:0] RD2;
    logic [DW-1:0] ResultW;
    logic [CW-1:0] WriteCount;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wb_regfile #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALUOutW   (ALUOutW),
        .ReadDataW (ReadDataW),
        .WriteRegW (WriteRegW),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .ResultW   (ResultW),
        .WriteCount(WriteCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance past the next rising edge; inputs change and outputs are
    // sampled mid-cycle, never on the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        RegWriteW = 1'b0; MemtoRegW = 1'b0;
        ALUOutW = 32'h0BAD_0BAD; ReadDataW = 32'h0BAD_F00D; WriteRegW = 5'd5;
        A1 = 5'd5; A2 = 5'd31;
        #23;
        total_cnt++;
        if (RD1 !== 32'h0) $display("FAIL reset_rd1_low: got %h want %h", RD1, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (RD2 !== 32'h0) $display("FAIL reset_rd2_low: got %h want %h", RD2, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (WriteCount !== 4'd0) $display("FAIL reset_cnt_low: got %0d want 0", WriteCount);
        else pass_cnt++;
        @(negedge CLK);
        RST = 1'b1;
        step();
        total_cnt++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0)
            $display("FAIL reset_read_after: got %h/%h want 0/0", RD1, RD2);
        else pass_cnt++;
        total_cnt++;
        if (WriteCount !== 4'd0) $display("FAIL reset_cnt_after: got %0d want 0", WriteCount);
        else pass_cnt++;
    endtask

    task automatic test_alu_write();
        RegWriteW = 1'b1; MemtoRegW = 1'b0;
        ALUOutW = 32'hDEAD_BEEF; ReadDataW = 32'h1111_1111; WriteRegW = 5'd8;
        A1 = 5'd8; A2 = 5'd9;
        #1;
        total_cnt++;
        if (ResultW !== 32'hDEAD_BEEF) $display("FAIL alu_resultw: got %h want %h", ResultW, 32'hDEAD_BEEF);
        else pass_cnt++;
        total_cnt++;
        if (RD1 !== 32'hDEAD_BEEF) $display("FAIL alu_bypass: got %h want %h", RD1, 32'hDEAD_BEEF);
        else pass_cnt++;
        total_cnt++;
        if (RD2 !== 32'h0) $display("FAIL alu_other_port: got %h want %h", RD2, 32'h0);
        else pass_cnt++;
        step();
        // Disabled write with junk on the other W-stage inputs must be inert.
        RegWriteW = 1'b0; WriteRegW = 5'd8; ALUOutW = 32'hCAFE_CAFE;
        #1;
        total_cnt++;
        if (RD1 !== 32'hDEAD_BEEF) $display("FAIL alu_array_read: got %h want %h", RD1, 32'hDEAD_BEEF);
        else pass_cnt++;
        step();
        total_cnt++;
        if (RD1 !== 32'hDEAD_BEEF) $display("FAIL alu_disabled_hold: got %h want %h", RD1, 32'hDEAD_BEEF);
        else pass_cnt++;
        total_cnt++;
        if (WriteCount !== 4'd1) $display("FAIL alu_cnt: got %0d want 1", WriteCount);
        else pass_cnt++;
    endtask

    task automatic test_load_select();
        RegWriteW = 1'b1; MemtoRegW = 1'b1;
        ReadDataW = 32'h1234_5678; ALUOutW = 32'hFFFF_FFFF; WriteRegW = 5'd9;
        A1 = 5'd8; A2 = 5'd1;
        #1;
        total_cnt++;
        if (ResultW !== 32'h1234_5678) $display("FAIL load_resultw: got %h want %h", ResultW, 32'h1234_5678);
        else pass_cnt++;
        step();
        RegWriteW = 1'b0;
        A2 = 5'd9;
        #1;
        total_cnt++;
        if (RD2 !== 32'h1234_5678) $display("FAIL load_read: got %h want %h", RD2, 32'h1234_5678);
        else pass_cnt++;
        total_cnt++;
        if (RD1 !== 32'hDEAD_BEEF) $display("FAIL load_reg8_kept: got %h want %h", RD1, 32'hDEAD_BEEF);
        else pass_cnt++;
        total_cnt++;
        if (WriteCount !== 4'd2) $display("FAIL load_cnt: got %0d want 2", WriteCount);
        else pass_cnt++;
    endtask

    task automatic test_zero_protect();
        RegWriteW = 1'b1; MemtoRegW = 1'b0;
        ALUOutW = 32'hAAAA_AAAA; WriteRegW = 5'd0;
        A1 = 5'd0; A2 = 5'd0;
        #1;
        total_cnt++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0)
            $display("FAIL zero_before: got %h/%h want 0/0", RD1, RD2);
        else pass_cnt++;
        step();
        RegWriteW = 1'b0;
        #1;
        total_cnt++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0)
            $display("FAIL zero_after: got %h/%h want 0/0", RD1, RD2);
        else pass_cnt++;
        total_cnt++;
        if (WriteCount !== 4'd2) $display("FAIL zero_cnt: got %0d want 2", WriteCount);
        else pass_cnt++;
    endtask

    task automatic test_dual_bypass();
        RegWriteW = 1'b1; MemtoRegW = 1'b0; ALUOutW = 32'h33; WriteRegW = 5'd3;
        A1 = 5'd8; A2 = 5'd9;
        #1;
        total_cnt++;
        if (RD1 !== 32'hDEAD_BEEF || RD2 !== 32'h1234_5678)
            $display("FAIL dual_nonmatch: got %h/%h want deadbeef/12345678", RD1, RD2);
        else pass_cnt++;
        step();
        ALUOutW = 32'h55; A1 = 5'd3; A2 = 5'd3;
        #1;
        total_cnt++;
        if (RD1 !== 32'h55 || RD2 !== 32'h55)
            $display("FAIL dual_bypass: got %h/%h want 55/55", RD1, RD2);
        else pass_cnt++;
        RegWriteW = 1'b0;
        #1;
        total_cnt++;
        if (RD1 !== 32'h33 || RD2 !== 32'h33)
            $display("FAIL dual_disabled: got %h/%h want 33/33", RD1, RD2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (RD1 !== 32'h33 || RD2 !== 32'h33)
            $display("FAIL dual_unchanged: got %h/%h want 33/33", RD1, RD2);
        else pass_cnt++;
        total_cnt++;
        if (WriteCount !== 4'd3) $display("FAIL dual_cnt: got %0d want 3", WriteCount);
        else pass_cnt++;
    endtask

    task automatic test_wrap_async_reset();
        // Fresh start so the count is exactly the number of writes below.
        #2 RST = 1'b0;
        #1 RST = 1'b1;
        MemtoRegW = 1'b0; RegWriteW = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            WriteRegW = AW'(i);
            ALUOutW   = 32'h100 + 32'(i);
            step();
            if (i == 16) begin
                total_cnt++;
                if (WriteCount !== 4'd0) $display("FAIL wrap_at_16: got %0d want 0", WriteCount);
                else pass_cnt++;
            end
        end
        RegWriteW = 1'b0;
        A1 = 5'd8; A2 = 5'd17;
        #1;
        total_cnt++;
        if (WriteCount !== 4'd1) $display("FAIL wrap_at_17: got %0d want 1", WriteCount);
        else pass_cnt++;
        total_cnt++;
        if (RD1 !== 32'h108 || RD2 !== 32'h111)
            $display("FAIL wrap_regs: got %h/%h want 108/111", RD1, RD2);
        else pass_cnt++;
        // Reset lands mid-cycle, well away from any clock edge.
        #1 RST = 1'b0;
        #1;
        total_cnt++;
        if (WriteCount !== 4'd0 || RD1 !== 32'h0 || RD2 !== 32'h0)
            $display("FAIL async_reset: got cnt %0d rd %h/%h want 0 0/0", WriteCount, RD1, RD2);
        else pass_cnt++;
        RegWriteW = 1'b1; WriteRegW = 5'd8; ALUOutW = 32'h77;
        step();
        total_cnt++;
        if (RD1 !== 32'h0 || WriteCount !== 4'd0)
            $display("FAIL reset_blocks_write: got rd %h cnt %0d want 0 0", RD1, WriteCount);
        else pass_cnt++;
        RegWriteW = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        total_cnt++;
        if (RD1 !== 32'h0) $display("FAIL reg8_after_reset: got %h want 0", RD1);
        else pass_cnt++;
        RegWriteW = 1'b1; WriteRegW = 5'd4; ALUOutW = 32'h44;
        step();
        RegWriteW = 1'b0; A2 = 5'd4;
        #1;
        total_cnt++;
        if (WriteCount !== 4'd1 || RD2 !== 32'h44)
            $display("FAIL first_write_after_reset: got cnt %0d rd %h want 1 44", WriteCount, RD2);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_select();
        test_zero_protect();
        test_dual_bypass();
        test_wrap_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
